display_shift_driver: RTL and testbench

DISPLAY_SHIFT_DRIVER -- requirements
Module: display_shift_driver

---
 rtl/display_shift_driver_pkg.sv | 25 ++
 rtl/serial_clk_gen.sv | 38 +++
 rtl/display_shift_driver.sv | 156 +++++++++++++++
 tb/tb_display_shift_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_shift_driver_pkg.sv
// Shared clock-display definitions: driver state encoding and frame geometry constants.
package display_shift_driver_pkg;

  // Driver FSM states
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StShiftLo = 3'd2,
    StShiftHi = 3'd3,
    StLatch   = 3'd4
  } drv_state_e;

  // segment_select value when no digit is addressed
  localparam logic [2:0] IDLE_SELECT    = 3'h7;
  // Digits per frame (seconds_lsd .. hours_msd)
  localparam int unsigned NUM_DIGITS     = 6;
  // Serial bits per digit: decimal point plus seven segments
  localparam int unsigned BITS_PER_DIGIT = 8;

  // True while the serial clock generator should be running
  function automatic logic is_shift_state(input drv_state_e st);
    return (st == StShiftLo) || (st == StShiftHi);
  endfunction

endpackage

// File: rtl/serial_clk_gen.sv
// Half-period timer for the serial shift clock. While enabled it counts HALF_PERIOD clk
// cycles and raises a one-cycle tick on the last one, then restarts from zero.
module serial_clk_gen #(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  // Terminal count; the counter never exceeds this value
  localparam logic [3:0] CntLast = 4'(HALF_PERIOD - 1);

  logic [3:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntLast);

  // Next count: hold at zero when idle, restart after each tick
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_shift_driver.sv
// Serialises the six clock-display digits into an external 74HC595-style shift register
// chain, hours_msd first, MSB (decimal point, always off) first, then pulses the latch.
// Every output is a flop fed from next-state decode, so outputs track the current state
// with no extra cycle of lag and no combinational path from the inputs.
module display_shift_driver
  import display_shift_driver_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_stb,
  input  logic [6:0] led_in,
  output logic [2:0] segment_select,
  output logic       serial_data,
  output logic       serial_clk,
  output logic       serial_latch,
  output logic       busy
);

  localparam logic [2:0] DigitFirst = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] BitFirst   = 3'(BITS_PER_DIGIT - 1);

  drv_state_e state_q, state_d;
  logic [2:0] digit_q, digit_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;

  logic       hp_en;
  logic       hp_tick;

  logic [2:0] sel_q, sel_d;
  logic       sdata_q, sdata_d;
  logic       sclk_q, sclk_d;
  logic       latch_q, latch_d;
  logic       busy_q, busy_d;

  assign hp_en = is_shift_state(state_q);

  serial_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_serial_clk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (hp_en),
    .tick (hp_tick)
  );

  // Frame sequencing: next state, digit/bit counters and shift register
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (refresh_stb) begin
          state_d = StLoad;
          digit_d = DigitFirst;
        end
      end
      StLoad: begin
        // Decimal point is always off, so a zero leads each byte
        shreg_d = {1'b0, led_in};
        bit_d   = BitFirst;
        state_d = StShiftLo;
      end
      StShiftLo: begin
        if (hp_tick) begin
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (hp_tick) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            state_d = StShiftLo;
          end else if (digit_q != 3'd0) begin
            digit_d = digit_q - 3'd1;
            state_d = StLoad;
          end else begin
            state_d = StLatch;
          end
        end
      end
      StLatch: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    sel_d   = IDLE_SELECT;
    sdata_d = 1'b0;
    sclk_d  = 1'b0;
    latch_d = 1'b0;
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StLoad: begin
        sel_d = digit_d;
      end
      StShiftLo: begin
        sel_d   = digit_d;
        sdata_d = shreg_d[7];
      end
      StShiftHi: begin
        // Shift register only moves on exit from the high phase, so data is held
        sel_d   = digit_d;
        sdata_d = shreg_d[7];
        sclk_d  = 1'b1;
      end
      StLatch: begin
        latch_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame without latching
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      digit_q <= 3'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      sel_q   <= IDLE_SELECT;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
    end
  end

  assign segment_select = sel_q;
  assign serial_data    = sdata_q;
  assign serial_clk     = sclk_q;
  assign serial_latch   = latch_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_display_shift_driver.sv
// Bench for display_shift_driver: one instance with HALF_PERIOD=1 and one with 3, each fed
// by a modelled segment mux. Frames are captured on serial_clk rising edges and compared
// against the expected 48-bit stream built from a 7-segment lookup of the digits.
module tb_display_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       stb       [2];
  logic [6:0] led       [2];
  logic [2:0] sel       [2];
  logic       sdata     [2];
  logic       sclk      [2];
  logic       slatch    [2];
  logic       busy      [2];
  logic [2:0] prev_sel  [2];
  logic [6:0] noise     [2];
  logic       glitch_en [2];
  logic [3:0] digit     [2][8];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [23:0] digs;
    bit          glitch;
    logic [47:0] exp_bits;
  } vec_t;

  vec_t tbl[4];

  display_shift_driver #(.HALF_PERIOD(1)) dut_hp1 (
    .clk           (clk),
    .reset         (rst[0]),
    .refresh_stb   (stb[0]),
    .led_in        (led[0]),
    .segment_select(sel[0]),
    .serial_data   (sdata[0]),
    .serial_clk    (sclk[0]),
    .serial_latch  (slatch[0]),
    .busy          (busy[0])
  );

  display_shift_driver #(.HALF_PERIOD(3)) dut_hp3 (
    .clk           (clk),
    .reset         (rst[1]),
    .refresh_stb   (stb[1]),
    .led_in        (led[1]),
    .segment_select(sel[1]),
    .serial_data   (sdata[1]),
    .serial_clk    (sclk[1]),
    .serial_latch  (slatch[1]),
    .busy          (busy[1])
  );

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  // Expected serial stream: hours_msd first, each digit as {dp=0, segments}
  function automatic logic [47:0] ref_stream(input logic [23:0] digs);
    logic [47:0] s;
    s = '0;
    for (int d = 5; d >= 0; d--) s = {s[39:0], 1'b0, seg7(digs[d*4 +: 4])};
    return s;
  endfunction

  // Segment mux; in glitch mode the pattern is only correct in the first cycle a digit is
  // addressed, and is random noise afterwards
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      led[u] = 7'h00;
      if (sel[u] <= 3'd5) begin
        if (glitch_en[u] && (sel[u] == prev_sel[u])) led[u] = noise[u];
        else led[u] = seg7(digit[u][sel[u]]);
      end
    end
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      prev_sel[u] <= sel[u];
      noise[u]    <= 7'($urandom);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, " sel"},   64'(sel[u]),    64'd7);
    check({tag, " sdata"}, 64'(sdata[u]),  64'd0);
    check({tag, " sclk"},  64'(sclk[u]),   64'd0);
    check({tag, " latch"}, 64'(slatch[u]), 64'd0);
    check({tag, " busy"},  64'(busy[u]),   64'd0);
  endtask

  // Runs one frame on instance u. Cycle n=1 is the first cycle after the accepted strobe.
  task automatic run_frame(input int u, input logic [23:0] digs, input bit glitch,
                           input bit extra, input int rst_at, input bit b2b, input bit started,
                           input logic [47:0] exp_bits, input string tag);
    int hp, len, edges, latches, latch_n, bad_hi, hi_run, last_rise, gap_short, gap_long;
    int post_busy;
    logic [47:0] got;
    logic prev_clk, idle_busy;
    logic [2:0] idle_sel;
    hp = (u == 0) ? 1 : 3;
    len = 6 * (1 + 16 * hp) + 1;
    edges = 0; latches = 0; latch_n = 0; bad_hi = 0; hi_run = 0; last_rise = 0;
    gap_short = 0; gap_long = 0; post_busy = 0; got = '0; prev_clk = 1'b0;
    idle_busy = 1'b1; idle_sel = 3'd0;
    for (int d = 0; d < 6; d++) digit[u][d] = digs[d*4 +: 4];
    glitch_en[u] = glitch;
    if (!started) begin
      @(negedge clk);
      stb[u] = 1'b1;
      @(negedge clk);
      stb[u] = 1'b0;
    end
    for (int n = 1; n <= len + 1; n++) begin
      if (n == 1) begin
        check({tag, " load_sel"}, 64'(sel[u]), 64'd5);
        check({tag, " busy_start"}, 64'(busy[u]), 64'd1);
      end
      if (sclk[u] && !prev_clk) begin
        got = {got[46:0], sdata[u]};
        edges++;
        if (last_rise > 0) begin
          if (n - last_rise == 2 * hp) gap_short++;
          else if (n - last_rise == 2 * hp + 1) gap_long++;
        end
        last_rise = n;
      end
      if (sclk[u]) hi_run++;
      else begin
        if (prev_clk && hi_run != hp) bad_hi++;
        hi_run = 0;
      end
      prev_clk = sclk[u];
      if (slatch[u]) begin
        latches++;
        latch_n = n;
      end
      if (n == len + 1) begin
        idle_busy = busy[u];
        idle_sel  = sel[u];
      end
      if (rst_at > 0 && n > rst_at && busy[u]) post_busy++;
      if (rst_at > 0 && n == rst_at + 1) begin
        check({tag, " rst_sel"},  64'(sel[u]),  64'd7);
        check({tag, " rst_sclk"}, 64'(sclk[u]), 64'd0);
        check({tag, " rst_busy"}, 64'(busy[u]), 64'd0);
      end
      rst[u] = (rst_at > 0 && n == rst_at);
      stb[u] = (extra && (n == 10 || n == len - 1 || n == len)) || (b2b && n == len + 1);
      if (n <= len) @(negedge clk);
    end
    if (b2b) @(negedge clk);
    stb[u] = 1'b0;
    rst[u] = 1'b0;
    if (rst_at > 0) begin
      check({tag, " rst_no_latch"}, 64'(latches), 64'd0);
      check({tag, " rst_stays_idle"}, 64'(post_busy), 64'd0);
    end else begin
      check({tag, " bits"}, 64'(got), 64'(exp_bits));
      check({tag, " edges"}, 64'(edges), 64'd48);
      check({tag, " latches"}, 64'(latches), 64'd1);
      check({tag, " latch_cycle"}, 64'(latch_n), 64'(len));
      check({tag, " idle_busy"}, 64'(idle_busy), 64'd0);
      check({tag, " idle_sel"}, 64'(idle_sel), 64'd7);
      check({tag, " high_runs"}, 64'(bad_hi), 64'd0);
      check({tag, " bit_gaps"}, 64'(gap_short), 64'd42);
      check({tag, " digit_gaps"}, 64'(gap_long), 64'd5);
    end
  endtask

  initial begin
    logic [23:0] digs;
    int u;
    tbl[0] = '{24'h123456, 1'b0, 48'h065B4F666D7D};
    tbl[1] = '{24'h000000, 1'b1, 48'h3F3F3F3F3F3F};
    tbl[2] = '{24'h888888, 1'b0, 48'h7F7F7F7F7F7F};
    tbl[3] = '{24'h970531, 1'b1, 48'h6F073F6D4F06};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      stb[i] = 1'b1;
      glitch_en[i] = 1'b0;
      for (int d = 0; d < 8; d++) digit[i][d] = 4'd0;
    end

    // Reset overrides a simultaneous strobe
    repeat (3) @(negedge clk);
    check_idle(0, "reset hp1");
    check_idle(1, "reset hp3");
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      stb[i] = 1'b0;
    end
    @(negedge clk);
    check_idle(0, "post_reset hp1");

    // Table vectors on both half-period settings
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        run_frame(i, tbl[k].digs, tbl[k].glitch, 1'b0, 0, 1'b0, 1'b0, tbl[k].exp_bits, "tbl");

    // Strobes mid-frame, in the last shift cycle and during LATCH are ignored
    run_frame(0, 24'h123456, 1'b0, 1'b1, 0, 1'b0, 1'b0, 48'h065B4F666D7D, "ignore hp1");
    run_frame(1, 24'h123456, 1'b1, 1'b1, 0, 1'b0, 1'b0, 48'h065B4F666D7D, "ignore hp3");

    // Reset at cycle 40 aborts the frame; next frame is complete
    run_frame(0, 24'h123456, 1'b0, 1'b0, 40, 1'b0, 1'b0, 48'h0, "abort hp1");
    run_frame(0, 24'h123456, 1'b0, 1'b0, 0, 1'b0, 1'b0, 48'h065B4F666D7D, "after_abort");

    // Back-to-back: strobe in the IDLE cycle right after LATCH
    run_frame(0, 24'h123456, 1'b0, 1'b0, 0, 1'b1, 1'b0, 48'h065B4F666D7D, "b2b first");
    run_frame(0, 24'h970531, 1'b1, 1'b0, 0, 1'b0, 1'b1, 48'h6F073F6D4F06, "b2b second");

    // Randomised frames against the reference stream
    for (int r = 0; r < 10; r++) begin
      u = r % 2;
      for (int d = 0; d < 6; d++) digs[d*4 +: 4] = 4'($urandom_range(9));
      run_frame(u, digs, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 1'b0, 1'b0,
                ref_stream(digs), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
